// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - shared types for the FIFO read-side stream controller
package fifo_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } rd_state_e;

  localparam int RD_BUF_DEPTH = 2;

endpackage

// File: rtl/fifo_rd_stream_if.sv
// rtl/fifo_rd_stream_if.sv - FIFO read port plus valid/ready output stream
interface fifo_rd_stream_if #(
  parameter int DATA_WIDTH = 8
) ();

  logic                  fifo_rd_en;
  logic                  fifo_empty;
  logic [DATA_WIDTH-1:0] fifo_dout;
  logic                  m_valid;
  logic [DATA_WIDTH-1:0] m_data;
  logic                  m_ready;

  modport master (
    output fifo_rd_en,
    input  fifo_empty,
    input  fifo_dout,
    output m_valid,
    output m_data,
    input  m_ready
  );

  modport slave (
    input  fifo_rd_en,
    output fifo_empty,
    output fifo_dout,
    input  m_valid,
    input  m_data,
    output m_ready
  );

endinterface

// File: rtl/fifo_rd_skid.sv
// rtl/fifo_rd_skid.sv - 2-entry circular buffer absorbing the FIFO read latency
module fifo_rd_skid
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_push,
  input  logic [DATA_WIDTH-1:0] i_din,
  input  logic                  i_pop,
  output logic [DATA_WIDTH-1:0] o_dout,
  output logic [1:0]            o_occ
);

  logic [DATA_WIDTH-1:0] r_mem [RD_BUF_DEPTH];
  logic                  r_wr_idx;
  logic                  r_rd_idx;
  logic [1:0]            r_occ;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int i = 0; i < RD_BUF_DEPTH; i++) begin
        r_mem[i] <= '0;
      end
      r_wr_idx <= 1'b0;
      r_rd_idx <= 1'b0;
      r_occ    <= 2'd0;
    end else begin
      if (i_push) begin
        r_mem[r_wr_idx] <= i_din;
        r_wr_idx        <= ~r_wr_idx;
      end
      if (i_pop) begin
        r_rd_idx <= ~r_rd_idx;
      end
      r_occ <= r_occ + {1'b0, i_push} - {1'b0, i_pop};
    end
  end

  assign o_dout = r_mem[r_rd_idx];
  assign o_occ  = r_occ;

  a_no_overflow: assert property (@(posedge i_clk) disable iff (i_rst)
    !(i_push && !i_pop && r_occ == 2'd2));

endmodule

// File: rtl/fifo_rd_stream.sv
// rtl/fifo_rd_stream.sv - drains a sync FIFO into a valid/ready stream at 1 word/clk
// Optional transfer counter enabled by FIFO_RD_STREAM_STATS_EN.
module fifo_rd_stream
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 8
`ifdef FIFO_RD_STREAM_STATS_EN
  ,
  parameter int CNT_WIDTH  = 16
`endif
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_en,
  output logic               o_busy,
  fifo_rd_stream_if.master   bus
`ifdef FIFO_RD_STREAM_STATS_EN
  ,
  output logic [CNT_WIDTH-1:0] o_xfer_cnt
`endif
);

  rd_state_e             r_state;
  rd_state_e             w_next;
  logic                  r_inflight;
  logic                  w_valid;
  logic                  w_pop;
  logic                  w_rd_en;
  logic [1:0]            w_occ;
  logic [2:0]            w_pend;
  logic [DATA_WIDTH-1:0] w_dout;

  fifo_rd_skid #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_skid (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .i_push(r_inflight),
    .i_din (bus.fifo_dout),
    .i_pop (w_pop),
    .o_dout(w_dout),
    .o_occ (w_occ)
  );

  assign w_valid = (w_occ != 2'd0);
  assign w_pop   = w_valid & bus.m_ready;

  // Words already owed to the buffer after this cycle's pop; pop implies occ>=1.
  assign w_pend  = {1'b0, w_occ} + {2'b00, r_inflight} - {2'b00, w_pop};
  assign w_rd_en = (r_state == RUN) & ~bus.fifo_empty & (w_pend < 3'd2);

  assign bus.fifo_rd_en = w_rd_en;
  assign bus.m_valid    = w_valid;
  assign bus.m_data     = w_dout;
  assign o_busy         = (r_state != IDLE);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state    <= IDLE;
      r_inflight <= 1'b0;
    end else begin
      r_state    <= w_next;
      r_inflight <= w_rd_en;
    end
  end

  // A read issued in the cycle en drops still counts as owed, so go to DRAIN.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: begin
        if (i_en) w_next = RUN;
      end
      RUN: begin
        if (!i_en) begin
          w_next = ((w_occ != 2'd0) || r_inflight || w_rd_en) ? DRAIN : IDLE;
        end
      end
      DRAIN: begin
        if (i_en) begin
          w_next = RUN;
        end else if (!r_inflight && ((w_occ == 2'd0) || (w_occ == 2'd1 && w_pop))) begin
          w_next = IDLE;
        end
      end
      default: w_next = IDLE;
    endcase
  end

`ifdef FIFO_RD_STREAM_STATS_EN
  logic [CNT_WIDTH-1:0] r_xfer_cnt;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_xfer_cnt <= '0;
    end else if (w_pop) begin
      r_xfer_cnt <= r_xfer_cnt + 1'b1;
    end
  end

  assign o_xfer_cnt = r_xfer_cnt;
`endif

endmodule

// File: tb/tb_fifo_rd_stream.sv
// tb/tb_fifo_rd_stream.sv - self-checking bench for fifo_rd_stream behind an 8-deep FIFO
module tb_fifo_rd_stream;
  import fifo_pkg::*;

  localparam int DW    = 8;
  localparam int DEPTH = 8;

  logic       clk   = 1'b0;
  logic       rst   = 1'b1;
  logic       en    = 1'b0;
  logic       wr    = 1'b0;
  logic [7:0] wdata = 8'h00;
  logic       ready = 1'b0;
  logic       busy;
`ifdef FIFO_RD_STREAM_STATS_EN
  logic [7:0] xfer_cnt;
`endif

  fifo_rd_stream_if #(.DATA_WIDTH(DW)) bus ();

  always #5 clk = ~clk;

  fifo_rd_stream #(
    .DATA_WIDTH(DW)
`ifdef FIFO_RD_STREAM_STATS_EN
    ,
    .CNT_WIDTH (8)
`endif
  ) dut (
    .i_clk (clk),
    .i_rst (rst),
    .i_en  (en),
    .o_busy(busy),
    .bus   (bus)
`ifdef FIFO_RD_STREAM_STATS_EN
    ,
    .o_xfer_cnt(xfer_cnt)
`endif
  );

  // Synchronous FIFO with registered read data
  logic [7:0] f_mem [DEPTH];
  int         f_rp, f_wp, f_cnt;
  logic       f_rd, f_wr;

  assign bus.fifo_empty = (f_cnt == 0);
  assign bus.m_ready    = ready;
  assign f_rd           = bus.fifo_rd_en && (f_cnt != 0);
  assign f_wr           = wr && (f_cnt < DEPTH);

  always @(posedge clk) begin
    if (rst) begin
      f_rp <= 0;
      f_wp <= 0;
      f_cnt <= 0;
      bus.fifo_dout <= 8'h00;
    end else begin
      if (f_rd) begin
        bus.fifo_dout <= f_mem[f_rp];
        f_rp <= (f_rp + 1) % DEPTH;
      end
      if (f_wr) begin
        f_mem[f_wp] <= wdata;
        f_wp <= (f_wp + 1) % DEPTH;
      end
      f_cnt <= f_cnt + int'(f_wr) - int'(f_rd);
    end
  end

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Reference model: buffered count, owed word, mode, pop count and write log
  int         m_occ = 0, m_inf = 0, m_popped = 0, m_cnt = 0;
  rd_state_e  m_state = IDLE;
  logic [7:0] wlog[$];
  bit         chk_on = 0;

  int         rd_cnt, pop_cnt, first_rd, first_val, first_pop, last_pop;
  logic [7:0] first_pop_data, last_pop_data;

  always @(negedge clk) begin
    bit e_valid, e_pop, e_rd;
    int n_occ;
    cyc++;
    e_valid = (m_occ > 0);
    e_pop   = e_valid && ready;
    e_rd    = (m_state == RUN) && (f_cnt != 0) && (m_occ + m_inf - int'(e_pop) < 2);
    if (chk_on) begin
      check("m_valid", bus.m_valid, e_valid);
      if (e_valid) begin
        if (m_popped < wlog.size()) check("m_data", bus.m_data, wlog[m_popped]);
        else check("m_data_phantom", bus.m_valid, 1'b0);
      end
      check("fifo_rd_en", bus.fifo_rd_en, e_rd);
      check("busy", busy, m_state != IDLE);
`ifdef FIFO_RD_STREAM_STATS_EN
      check("xfer_cnt", xfer_cnt, m_cnt[7:0]);
`endif
    end
    if (f_rd) begin
      rd_cnt++;
      if (first_rd < 0) first_rd = cyc;
    end
    if (bus.m_valid && first_val < 0) first_val = cyc;
    if (bus.m_valid && ready) begin
      pop_cnt++;
      if (first_pop < 0) begin
        first_pop = cyc;
        first_pop_data = bus.m_data;
      end
      last_pop = cyc;
      last_pop_data = bus.m_data;
    end
    if (rst) begin
      m_occ = 0; m_inf = 0; m_popped = 0; m_cnt = 0; m_state = IDLE;
      wlog.delete();
      chk_on = 1;
    end else begin
      if (wr && f_cnt < DEPTH) wlog.push_back(wdata);
      n_occ = m_occ + m_inf - int'(e_pop);
      case (m_state)
        IDLE:  if (en) m_state = RUN;
        RUN:   if (!en) m_state = (m_occ > 0 || m_inf != 0 || e_rd) ? DRAIN : IDLE;
        DRAIN: if (en) m_state = RUN; else if (n_occ == 0 && m_inf == 0) m_state = IDLE;
        default: m_state = IDLE;
      endcase
      m_occ = n_occ;
      m_inf = int'(e_rd);
      m_popped += int'(e_pop);
      m_cnt = (m_cnt + int'(e_pop)) % 256;
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clr_obs();
    rd_cnt = 0; pop_cnt = 0;
    first_rd = -1; first_val = -1; first_pop = -1; last_pop = -1;
  endtask

  task automatic do_reset();
    rst = 1; en = 0; wr = 0; ready = 0;
    tick(2);
    rst = 0;
  endtask

  task automatic write_words(input int start, input int n);
    for (int i = 0; i < n; i++) begin
      wr = 1;
      wdata = 8'(start + i);
      tick(1);
    end
    wr = 0;
  endtask

  task automatic wait_pops(input string nm, input int n, input int budget);
    int k = 0;
    while (pop_cnt < n && k < budget) begin
      tick(1);
      k++;
    end
    check(nm, pop_cnt, n);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    clr_obs();

    // Reset, then FIFO filled while disabled
    do_reset();
    check("rst_m_valid", bus.m_valid, 1'b0);
    check("rst_rd_en", bus.fifo_rd_en, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_m_data", bus.m_data, 8'h00);
`ifdef FIFO_RD_STREAM_STATS_EN
    check("rst_xfer_cnt", xfer_cnt, 8'd0);
`endif
    write_words(1, 8);
    tick(5);
    check("idle_m_valid", bus.m_valid, 1'b0);
    check("idle_busy", busy, 1'b0);
    check("idle_reads", rd_cnt, 0);

    // Full-rate stream
    clr_obs();
    ready = 1; en = 1;
    wait_pops("stream_pops", 8, 40);
    check("stream_latency", first_val - first_rd, 2);
    check("stream_back2back", last_pop - first_pop, 7);
    check("stream_first", first_pop_data, 8'h01);
    check("stream_last", last_pop_data, 8'h08);
    en = 0;
    tick(3);

    // Backpressure
    do_reset();
    write_words(1, 8);
    clr_obs();
    ready = 0; en = 1;
    tick(10);
    check("bp_reads", rd_cnt, 2);
    check("bp_hold_data", bus.m_data, 8'h01);
    check("bp_hold_valid", bus.m_valid, 1'b1);
    ready = 1;
    wait_pops("bp_pops", 8, 40);
    check("bp_last", last_pop_data, 8'h08);
    en = 0;
    tick(3);

    // en drops the cycle after the first read
    do_reset();
    write_words(1, 8);
    clr_obs();
    ready = 1; en = 1;
    for (int k = 0; k < 10 && rd_cnt == 0; k++) tick(1);
    en = 0;
    for (int k = 0; k < 20 && busy; k++) tick(1);
    check("drain_idle", busy, 1'b0);
    check("drain_reads", rd_cnt, 2);
    check("drain_pops", pop_cnt, 2);
    tick(10);
    check("drain_no_more_rd", rd_cnt, 2);

    // Empty FIFO, then a single word
    do_reset();
    clr_obs();
    ready = 1; en = 1;
    tick(5);
    check("empty_no_rd", rd_cnt, 0);
    write_words(8'hA5, 1);
    tick(5);
    check("single_reads", rd_cnt, 1);
    check("single_pops", pop_cnt, 1);
    check("single_data", first_pop_data, 8'hA5);
    en = 0;
    tick(3);

    // Random traffic with en toggling and random backpressure
    do_reset();
    for (int i = 0; i < 1500; i++) begin
      wr    = ($urandom_range(2) != 0);
      wdata = 8'($urandom);
      en    = ($urandom_range(7) != 0);
      ready = $urandom_range(1);
      tick(1);
    end
    wr = 0; en = 1; ready = 1;
    tick(30);
    check("rand_fifo_drained", f_cnt, 0);
    check("rand_buf_drained", bus.m_valid, 1'b0);
    en = 0;
    tick(3);

`ifdef FIFO_RD_STREAM_STATS_EN
    // Counter wrap over 300 pops, then mid-stream reset
    do_reset();
    clr_obs();
    en = 1; ready = 1;
    begin
      int nw = 0;
      while (nw < 300) begin
        if (f_cnt < DEPTH - 1) begin
          wr = 1;
          wdata = 8'(nw);
          nw++;
        end else begin
          wr = 0;
        end
        tick(1);
      end
      wr = 0;
    end
    wait_pops("stats_pops", 300, 400);
    check("stats_wrap", xfer_cnt, 8'd44);
    write_words(1, 6);
    tick(1);
    rst = 1;
    tick(1);
    rst = 0;
    check("stats_rst_cnt", xfer_cnt, 8'd0);
    check("stats_rst_valid", bus.m_valid, 1'b0);
    en = 0;
    tick(3);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
